// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command controller: ASCII command
// bytes, acknowledge codes, FSM state type and a counter width helper.
package uart_cmd_pkg;

   localparam logic [7:0] ASCII_Y    = 8'h59;
   localparam logic [7:0] ASCII_Y_LC = 8'h79;
   localparam logic [7:0] ASCII_N    = 8'h4E;
   localparam logic [7:0] ASCII_N_LC = 8'h6E;
   localparam logic [7:0] ASCII_R    = 8'h52;
   localparam logic [7:0] ASCII_R_LC = 8'h72;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_0    = 8'h30;

   localparam logic [7:0] ACK_K = 8'h4B;
   localparam logic [7:0] ACK_E = 8'h45;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_CH = 2'd1,
      ACK     = 2'd2
   } state_t;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/cmd_timer.sv
// Up-counter with synchronous clear and enable that saturates at TERMINAL and
// flags when the terminal value is held.
module cmd_timer #(
   parameter int          WIDTH    = 8,
   parameter int unsigned TERMINAL = 255
) (
   input  logic CLK,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge CLK) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != TERM_V)) begin
         count_reg <= count_reg + WIDTH'(1);
      end
   end

   assign terminal = (count_reg == TERM_V);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Two-byte UART command decoder driving NUM_CH control pins, with a single
// acknowledge byte per command, a channel-byte timeout and a fail-safe watchdog.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int                NUM_CH         = 4,
   parameter logic [NUM_CH-1:0] DEFAULT_STATE  = {NUM_CH{1'b1}},
   parameter int unsigned       TIMEOUT_CYCLES = 1_200_000,
   parameter int unsigned       WDOG_CYCLES    = 0
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_data_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [NUM_CH-1:0] control,
   output logic [4:0]        led_state
);

   localparam int unsigned TO_TERM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam int unsigned WD_TERM = (WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0;
   localparam bit          WDOG_EN = (WDOG_CYCLES > 0);

   state_t            state_reg, state_next;
   logic              tx_valid_reg;
   logic [7:0]        tx_data_reg;
   logic              pending_reg;
   logic              err_reg;
   logic              tripped_reg;
   logic              last_val_reg;
   logic [NUM_CH-1:0] control_reg, control_next;

   logic              ack_go;
   logic [7:0]        ack_code;
   logic              pend_load;
   logic              pend_val;
   logic              ch_write;
   logic              load_default;
   logic              k_event;
   logic              wdog_trip;
   logic              timeout_hit;
   logic              wdog_term;
   logic [NUM_CH-1:0] digit_hit;
   logic              digit_ok;

   cmd_timer #(
      .WIDTH    (cnt_width(TO_TERM)),
      .TERMINAL (TO_TERM)
   ) u_timeout (
      .CLK      (CLK),
      .rst      (rst),
      .clear    ((state_reg != WAIT_CH) || rx_data_valid),
      .enable   (state_reg == WAIT_CH),
      .terminal (timeout_hit)
   );

   cmd_timer #(
      .WIDTH    (cnt_width(WD_TERM)),
      .TERMINAL (WD_TERM)
   ) u_wdog (
      .CLK      (CLK),
      .rst      (rst),
      .clear    (k_event),
      .enable   (WDOG_EN),
      .terminal (wdog_term)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign digit_hit[gi]    = (rx_data == 8'(ASCII_0 + gi));
         // A channel write beats both 'R' and a watchdog trip on the same cycle.
         assign control_next[gi] = (ch_write && digit_hit[gi]) ? pending_reg :
                                   (load_default || wdog_trip) ? DEFAULT_STATE[gi] :
                                   control_reg[gi];
      end
   endgenerate

   assign digit_ok = |digit_hit;

   always_comb begin
      state_next   = state_reg;
      ack_go       = 1'b0;
      ack_code     = ACK_E;
      pend_load    = 1'b0;
      pend_val     = pending_reg;
      ch_write     = 1'b0;
      load_default = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rx_data_valid) begin
               case (rx_data)
                  ASCII_Y, ASCII_Y_LC: begin
                     pend_load  = 1'b1;
                     pend_val   = 1'b0;
                     state_next = WAIT_CH;
                  end
                  ASCII_N, ASCII_N_LC: begin
                     pend_load  = 1'b1;
                     pend_val   = 1'b1;
                     state_next = WAIT_CH;
                  end
                  ASCII_R, ASCII_R_LC: begin
                     load_default = 1'b1;
                     ack_go       = 1'b1;
                     ack_code     = ACK_K;
                  end
                  ASCII_CR, ASCII_LF: begin
                     ack_go = 1'b0;
                  end
                  default: begin
                     ack_go = 1'b1;
                  end
               endcase
            end
         end
         WAIT_CH: begin
            if (rx_data_valid) begin
               ack_go = 1'b1;
               if (digit_ok) begin
                  ch_write = 1'b1;
                  ack_code = ACK_K;
               end
            end else if (timeout_hit) begin
               ack_go = 1'b1;
            end
         end
         ACK: begin
            if (tx_valid_reg && tx_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (ack_go) begin
         state_next = ACK;
      end
   end

   assign k_event   = ack_go && (ack_code == ACK_K);
   assign wdog_trip = WDOG_EN && wdog_term && !tripped_reg && !k_event;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_reg    <= IDLE;
         tx_valid_reg <= 1'b0;
         tx_data_reg  <= 8'h00;
         pending_reg  <= 1'b0;
         err_reg      <= 1'b0;
         tripped_reg  <= 1'b0;
         last_val_reg <= 1'b1;
         control_reg  <= DEFAULT_STATE;
      end else begin
         state_reg   <= state_next;
         control_reg <= control_next;
         if (pend_load) begin
            pending_reg <= pend_val;
         end
         if (ack_go) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= ack_code;
            err_reg      <= (ack_code == ACK_E);
         end else if ((state_reg == ACK) && tx_valid_reg && tx_ready) begin
            tx_valid_reg <= 1'b0;
         end
         if (ch_write) begin
            last_val_reg <= pending_reg;
         end
         if (k_event) begin
            tripped_reg <= 1'b0;
         end else if (wdog_trip) begin
            tripped_reg <= 1'b1;
         end
      end
   end

   assign tx_valid  = tx_valid_reg;
   assign tx_data   = tx_data_reg;
   assign control   = control_reg;
   assign led_state = {~last_val_reg, tripped_reg, err_reg, (state_reg != IDLE), last_val_reg};

endmodule
